// File: rtl/dispensador_bebida.sv
// Drink dispenser: answers the menu FSM's REQ/ACK handshake, runs a timed pour and purge, and counts drinks served.
// Optional cup sensing (CUP port, CUP_WAIT state, CUP_TIMEOUT) is enabled with `define CUP_SENSE_EN.
module dispensador_bebida #(
    parameter int POUR_1    = 8,
    parameter int POUR_2    = 12,
    parameter int POUR_3    = 16,
    parameter int PURGE_CYC = 2,
    parameter int CW        = 8
`ifdef CUP_SENSE_EN
    , parameter int CUP_TIMEOUT = 20
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       REQ,
    input  logic [2:0] DISP,
`ifdef CUP_SENSE_EN
    input  logic       CUP,
`endif
    output logic       ACK,
    output logic       BUSY,
    output logic [2:0] VALVE,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] SERVED
);

`ifdef CUP_SENSE_EN
    typedef enum logic [2:0] {S_IDLE, S_POUR, S_PURGE, S_WAIT_REL, S_CUP_WAIT} state_t;
    localparam logic [CW-1:0] L_CUP_TO = CW'(CUP_TIMEOUT - 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_POUR, S_PURGE, S_WAIT_REL} state_t;
`endif

    localparam logic [CW-1:0] L_POUR1  = CW'(POUR_1 - 1);
    localparam logic [CW-1:0] L_POUR2  = CW'(POUR_2 - 1);
    localparam logic [CW-1:0] L_POUR3  = CW'(POUR_3 - 1);
    localparam logic [CW-1:0] L_PURGE  = CW'(PURGE_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_code, w_code_nxt;
    logic [2:0]    r_valve, w_valve_nxt;
    logic          r_ack, w_ack_nxt;
    logic          r_busy;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic [7:0]    r_served, w_served_nxt;
    logic          w_valid;

    // Counter preload for a pour: the cycle count minus one, so count 0 is the last valve-open cycle.
    function automatic logic [CW-1:0] pour_load(input logic [2:0] code);
        case (code)
            3'b001:  pour_load = L_POUR1;
            3'b010:  pour_load = L_POUR2;
            3'b100:  pour_load = L_POUR3;
            default: pour_load = L_POUR1;
        endcase
    endfunction

    assign w_valid = (DISP == 3'b001) || (DISP == 3'b010) || (DISP == 3'b100);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_code_nxt   = r_code;
        w_valve_nxt  = r_valve;
        w_ack_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_served_nxt = r_served;
        case (r_state)
            S_IDLE: begin
                if (REQ && w_valid) begin
                    w_ack_nxt  = 1'b1;
                    w_code_nxt = DISP;
`ifdef CUP_SENSE_EN
                    if (!CUP) begin
                        w_state_nxt = S_CUP_WAIT;
                        w_cnt_nxt   = L_CUP_TO;
                    end else begin
                        w_state_nxt = S_POUR;
                        w_valve_nxt = DISP;
                        w_cnt_nxt   = pour_load(DISP);
                    end
`else
                    w_state_nxt = S_POUR;
                    w_valve_nxt = DISP;
                    w_cnt_nxt   = pour_load(DISP);
`endif
                end else if (REQ) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef CUP_SENSE_EN
            S_CUP_WAIT: begin
                if (CUP) begin
                    w_state_nxt = S_POUR;
                    w_valve_nxt = r_code;
                    w_cnt_nxt   = pour_load(r_code);
                end else if (r_cnt == CNT_ZERO) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
`endif
            S_POUR: begin
`ifdef CUP_SENSE_EN
                // Cup removed mid-pour: shut the valve and abort without counting the drink.
                if (!CUP) begin
                    w_valve_nxt = 3'b000;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                end else
`endif
                if (r_cnt == CNT_ZERO) begin
                    w_valve_nxt = 3'b000;
                    w_cnt_nxt   = L_PURGE;
                    w_state_nxt = S_PURGE;
                end else begin
                    w_valve_nxt = r_code;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            S_PURGE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_WAIT_REL;
                    w_served_nxt = (r_served == 8'hFF) ? 8'hFF : r_served + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_WAIT_REL: begin
                if (!REQ) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_REL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valve_nxt = 3'b000;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops the valve without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_code   <= 3'b000;
            r_valve  <= 3'b000;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_served <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_valve  <= w_valve_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_served <= w_served_nxt;
        end
    end

    assign ACK    = r_ack;
    assign BUSY   = r_busy;
    assign VALVE  = r_valve;
    assign DONE   = r_done;
    assign ERR    = r_err;
    assign SERVED = r_served;

endmodule

// File: tb/tb_dispensador_bebida.sv
// Self-checking bench for dispensador_bebida: per-scenario timing checks plus an outcome scoreboard.
module tb_dispensador_bebida;

    localparam int POUR_A = 8;
    localparam int POUR_B = 12;
    localparam int POUR_C = 16;
    localparam int CUP_TO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       REQ = 1'b0;
    logic [2:0] DISP = 3'b000;
`ifdef CUP_SENSE_EN
    logic       CUP = 1'b1;
`endif
    logic       ACK, BUSY, DONE, ERR;
    logic [2:0] VALVE;
    logic [7:0] SERVED;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       is_done;
        logic [7:0] served;
    } exp_t;
    exp_t       sb_q[$];
    exp_t       sb_e;
    logic [7:0] model_served = 8'h00;

    dispensador_bebida dut (
        .clk    (clk),
        .reset  (reset),
        .REQ    (REQ),
        .DISP   (DISP),
`ifdef CUP_SENSE_EN
        .CUP    (CUP),
`endif
        .ACK    (ACK),
        .BUSY   (BUSY),
        .VALVE  (VALVE),
        .DONE   (DONE),
        .ERR    (ERR),
        .SERVED (SERVED)
    );

    always #5 clk = ~clk;

    // Scoreboard: every DONE/ERR pulse must match the oldest expected outcome.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones({ACK, DONE, ERR}) > 1) begin
                errors++;
                $display("FAIL excl: ACK=%b DONE=%b ERR=%b, required at most one high", ACK, DONE, ERR);
            end
            if (DONE || ERR) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: DONE=%b ERR=%b with no outcome expected", DONE, ERR);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (DONE !== sb_e.is_done || SERVED !== sb_e.served) begin
                        errors++;
                        $display("FAIL sb_outcome: DONE=%b SERVED=%h, required DONE=%b SERVED=%h",
                                 DONE, SERVED, sb_e.is_done, sb_e.served);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({ACK, BUSY, VALVE, DONE, ERR, SERVED} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async: outs=%b, required all zero", {ACK, BUSY, VALVE, DONE, ERR, SERVED});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (BUSY !== 1'b0 || SERVED !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: BUSY=%b SERVED=%h, required 0 00", BUSY, SERVED);
        end
    endtask

    task automatic test_pour(input logic [2:0] code, input int len, input int drop_at);
        logic [2:0] exp_valve;
        REQ  = 1'b1;
        DISP = code;
        model_served = (model_served == 8'hFF) ? 8'hFF : model_served + 8'd1;
        sb_q.push_back('{1'b1, model_served});
        for (int k = 0; k <= len + 3; k++) begin
            @(negedge clk);
            exp_valve = (k < len) ? code : 3'b000;
            checks += 5;
            if (VALVE !== exp_valve) begin
                errors++;
                $display("FAIL pour_valve k=%0d: VALVE=%b, required %b", k, VALVE, exp_valve);
            end
            if (ACK !== (k == 0)) begin
                errors++;
                $display("FAIL pour_ack k=%0d: ACK=%b, required %b", k, ACK, (k == 0));
            end
            if (DONE !== (k == len + 2)) begin
                errors++;
                $display("FAIL pour_done k=%0d: DONE=%b, required %b", k, DONE, (k == len + 2));
            end
            if (BUSY !== (k <= len + 2)) begin
                errors++;
                $display("FAIL pour_busy k=%0d: BUSY=%b, required %b", k, BUSY, (k <= len + 2));
            end
            if (ERR !== 1'b0) begin
                errors++;
                $display("FAIL pour_err k=%0d: ERR=%b, required 0", k, ERR);
            end
            if (k == 0) DISP = 3'b111;
            if (k + 1 == drop_at) REQ = 1'b0;
            if (drop_at < 0 && k == len + 2) REQ = 1'b0;
        end
        checks++;
        if (SERVED !== model_served) begin
            errors++;
            $display("FAIL pour_served: SERVED=%h, required %h", SERVED, model_served);
        end
        DISP = 3'b000;
    endtask

    task automatic test_invalid();
        logic [2:0] codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        for (int c = 0; c < 5; c++) begin
            REQ  = 1'b1;
            DISP = codes[c];
            sb_q.push_back('{1'b0, model_served});
            for (int k = 0; k <= 3; k++) begin
                @(negedge clk);
                checks += 4;
                if (ERR !== (k == 0)) begin
                    errors++;
                    $display("FAIL inv_err code=%b k=%0d: ERR=%b, required %b", codes[c], k, ERR, (k == 0));
                end
                if (ACK !== 1'b0) begin
                    errors++;
                    $display("FAIL inv_ack code=%b k=%0d: ACK=%b, required 0", codes[c], k, ACK);
                end
                if (VALVE !== 3'b000) begin
                    errors++;
                    $display("FAIL inv_valve code=%b k=%0d: VALVE=%b, required 000", codes[c], k, VALVE);
                end
                if (BUSY !== (k < 3)) begin
                    errors++;
                    $display("FAIL inv_busy code=%b k=%0d: BUSY=%b, required %b", codes[c], k, BUSY, (k < 3));
                end
                if (k == 2) REQ = 1'b0;
            end
        end
        DISP = 3'b000;
    endtask

    task automatic test_reset_mid_pour();
        REQ  = 1'b1;
        DISP = 3'b100;
        sb_q.push_back('{1'b1, model_served});
        repeat (5) @(negedge clk);
        checks++;
        if (VALVE !== 3'b100) begin
            errors++;
            $display("FAIL midreset_pre: VALVE=%b, required 100", VALVE);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ACK, BUSY, VALVE, DONE, ERR, SERVED} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_async: outs=%b, required all zero", {ACK, BUSY, VALVE, DONE, ERR, SERVED});
        end
        REQ  = 1'b0;
        DISP = 3'b000;
        sb_q.delete();
        model_served = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic seen;
        for (int i = 0; i < 256; i++) begin
            REQ  = 1'b1;
            DISP = 3'b001;
            model_served = (model_served == 8'hFF) ? 8'hFF : model_served + 8'd1;
            sb_q.push_back('{1'b1, model_served});
            seen = 1'b0;
            for (int c = 0; c < 30 && !seen; c++) begin
                @(negedge clk);
                if (DONE === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL sat_timeout pour=%0d: no DONE within 30 cycles", i);
            end
            REQ = 1'b0;
            @(negedge clk);
            @(negedge clk);
            if (i == 254 || i == 255) begin
                checks++;
                if (SERVED !== 8'hFF) begin
                    errors++;
                    $display("FAIL sat_served pour=%0d: SERVED=%h, required FF", i, SERVED);
                end
            end
        end
        DISP = 3'b000;
    endtask

`ifdef CUP_SENSE_EN
    task automatic test_cup_timeout();
        CUP  = 1'b0;
        REQ  = 1'b1;
        DISP = 3'b001;
        sb_q.push_back('{1'b0, model_served});
        for (int k = 0; k <= CUP_TO + 1; k++) begin
            @(negedge clk);
            checks += 4;
            if (ACK !== (k == 0)) begin
                errors++;
                $display("FAIL cupto_ack k=%0d: ACK=%b, required %b", k, ACK, (k == 0));
            end
            if (ERR !== (k == CUP_TO)) begin
                errors++;
                $display("FAIL cupto_err k=%0d: ERR=%b, required %b", k, ERR, (k == CUP_TO));
            end
            if (VALVE !== 3'b000) begin
                errors++;
                $display("FAIL cupto_valve k=%0d: VALVE=%b, required 000", k, VALVE);
            end
            if (BUSY !== (k <= CUP_TO)) begin
                errors++;
                $display("FAIL cupto_busy k=%0d: BUSY=%b, required %b", k, BUSY, (k <= CUP_TO));
            end
            if (k == CUP_TO) REQ = 1'b0;
        end
        CUP  = 1'b1;
        DISP = 3'b000;
    endtask

    task automatic test_cup_abort();
        logic [7:0] before;
        before = model_served;
        CUP  = 1'b1;
        REQ  = 1'b1;
        DISP = 3'b010;
        sb_q.push_back('{1'b0, model_served});
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks += 3;
            if (VALVE !== ((k < 5) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL cupab_valve k=%0d: VALVE=%b, required %b", k, VALVE, (k < 5) ? 3'b010 : 3'b000);
            end
            if (ERR !== (k == 5)) begin
                errors++;
                $display("FAIL cupab_err k=%0d: ERR=%b, required %b", k, ERR, (k == 5));
            end
            if (DONE !== 1'b0) begin
                errors++;
                $display("FAIL cupab_done k=%0d: DONE=%b, required 0", k, DONE);
            end
            if (k == 4) CUP = 1'b0;
            if (k == 5) REQ = 1'b0;
        end
        checks += 2;
        if (SERVED !== before) begin
            errors++;
            $display("FAIL cupab_served: SERVED=%h, required %h", SERVED, before);
        end
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cupab_busy: BUSY=%b, required 0", BUSY);
        end
        CUP  = 1'b1;
        DISP = 3'b000;
    endtask
`endif

    initial begin
        test_reset();
        test_pour(3'b001, POUR_A, -1);
        test_invalid();
        test_pour(3'b100, POUR_C, 3);
        test_pour(3'b010, POUR_B, -1);
        test_reset_mid_pour();
        test_saturation();
`ifdef CUP_SENSE_EN
        test_cup_timeout();
        test_cup_abort();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d outcomes never observed, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
